// File: rtl/alu16_seq.sv
// alu16_seq: sequenced WIDTH-bit ALU with a start/busy/done handshake and registered results.
// Define ALU16_SEQ_MUL_EN to build the iterative unsigned MUL datapath and its RUN state.
module alu16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] alu_in_a,
  input  logic [WIDTH-1:0] alu_in_b,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             h_in,
  output logic [WIDTH-1:0] alu_out,
  output logic             c_out,
  output logic             z_out,
  output logic             n_out,
  output logic             v_out,
  output logic             h_out,
  output logic             busy,
  output logic             done
);
  localparam int HALF = WIDTH / 2;

  localparam logic [2:0] OP_TST = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_CMP = 3'd3;
  localparam logic [2:0] OP_SEX = 3'd4;
  localparam logic [2:0] OP_ADC = 3'd5;
  localparam logic [2:0] OP_SBC = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] flag_src_s;
  logic             c_s;
  logic             v_s;
  logic             z_s;
  logic             n_s;
  logic             carry_in_s;
  logic             issue_s;

  // Single-cycle result and flags, computed straight from the request inputs
  always_comb begin
    sum_s      = {1'b0, alu_in_a} + {1'b0, alu_in_b};
    res_s      = alu_in_a;
    flag_src_s = alu_in_a;
    c_s        = c_in;
    v_s        = v_in;
    carry_in_s = ((op == OP_ADC) || (op == OP_SBC)) ? c_in : 1'b0;
    case (op)
      OP_TST: begin
        v_s = 1'b0;
      end
      OP_ADD, OP_ADC: begin
        sum_s      = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {{WIDTH{1'b0}}, carry_in_s};
        res_s      = sum_s[WIDTH-1:0];
        flag_src_s = sum_s[WIDTH-1:0];
        c_s        = sum_s[WIDTH];
        v_s        = (alu_in_a[WIDTH-1] == alu_in_b[WIDTH-1]) &&
                     (sum_s[WIDTH-1] != alu_in_a[WIDTH-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        // bit WIDTH of the widened difference is the borrow
        sum_s      = {1'b0, alu_in_a} - {1'b0, alu_in_b} - {{WIDTH{1'b0}}, carry_in_s};
        res_s      = (op == OP_CMP) ? alu_in_a : sum_s[WIDTH-1:0];
        flag_src_s = sum_s[WIDTH-1:0];
        c_s        = sum_s[WIDTH];
        v_s        = (alu_in_a[WIDTH-1] != alu_in_b[WIDTH-1]) &&
                     (sum_s[WIDTH-1] != alu_in_a[WIDTH-1]);
      end
      OP_SEX: begin
        res_s      = {{HALF{alu_in_a[HALF-1]}}, alu_in_a[HALF-1:0]};
        flag_src_s = res_s;
      end
      OP_MUL: begin
        res_s      = alu_in_a;
        flag_src_s = alu_in_a;
      end
      default: begin
        res_s      = alu_in_a;
        flag_src_s = alu_in_a;
      end
    endcase
    z_s = (flag_src_s == {WIDTH{1'b0}});
    n_s = flag_src_s[WIDTH-1];
  end

`ifdef ALU16_SEQ_MUL_EN
  localparam int CW = $clog2(HALF + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_s;
  logic [HALF-1:0]  mplier_r;
  logic [CW-1:0]    cnt_r;
  logic             mul_v_r;
  logic             mul_h_r;
  logic             mul_go_s;
  logic             last_s;

  assign issue_s  = start && (state_r == IDLE) && (op != OP_MUL);
  assign mul_go_s = start && (state_r == IDLE) && (op == OP_MUL);
  assign last_s   = (state_r == RUN) && (cnt_r == CW'(1));
  assign acc_s    = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mul_go_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end
`else
  assign issue_s = start;
  assign busy    = 1'b0;
`endif

  // Result/flag registers, done pulse and the shift-add multiplier
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_out  <= {WIDTH{1'b0}};
      c_out    <= 1'b0;
      z_out    <= 1'b0;
      n_out    <= 1'b0;
      v_out    <= 1'b0;
      h_out    <= 1'b0;
      done     <= 1'b0;
`ifdef ALU16_SEQ_MUL_EN
      busy     <= 1'b0;
      mcand_r  <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      mplier_r <= {HALF{1'b0}};
      cnt_r    <= {CW{1'b0}};
      mul_v_r  <= 1'b0;
      mul_h_r  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (issue_s) begin
        alu_out <= res_s;
        c_out   <= c_s;
        z_out   <= z_s;
        n_out   <= n_s;
        v_out   <= v_s;
        h_out   <= h_in;
        done    <= 1'b1;
      end
`ifdef ALU16_SEQ_MUL_EN
      else if (mul_go_s) begin
        mcand_r  <= {{HALF{1'b0}}, alu_in_a[HALF-1:0]};
        mplier_r <= alu_in_b[HALF-1:0];
        acc_r    <= {WIDTH{1'b0}};
        cnt_r    <= CW'(HALF);
        mul_v_r  <= v_in;
        mul_h_r  <= h_in;
        busy     <= 1'b1;
      end else if (state_r == RUN) begin
        acc_r    <= acc_s;
        mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[HALF-1:1]};
        cnt_r    <= cnt_r - CW'(1);
        if (last_s) begin
          // N is left as it was; V and H come from the request
          alu_out <= acc_s;
          c_out   <= acc_s[HALF-1];
          z_out   <= (acc_s == {WIDTH{1'b0}});
          v_out   <= mul_v_r;
          h_out   <= mul_h_r;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
      end
`endif
    end
  end

endmodule
